// File: rtl/nanorv32_tcm_mbank_arbitrer_if.sv
// Bus bundle between the CPU code/data ports, the multi-bank arbiter and the TCM banks.
// The slave modport is the arbiter's view; the master modport is the CPU/bank environment.
interface nanorv32_tcm_mbank_arbitrer_if #(
  parameter int NBANK   = 2,
  parameter int BANK_AW = 13
);
  logic [31:0]            cpu_codeif_addr;
  logic                   cpu_codeif_req;
  logic [31:0]            codeif_cpu_rdata;
  logic                   codeif_cpu_early_ready;
  logic                   codeif_cpu_err;

  logic [31:0]            cpu_dataif_addr;
  logic [31:0]            cpu_dataif_wdata;
  logic [3:0]             cpu_dataif_bytesel;
  logic                   cpu_dataif_req;
  logic [31:0]            dataif_cpu_rdata;
  logic                   dataif_cpu_early_ready;
  logic                   dataif_cpu_err;

  logic [NBANK-1:0]         bank_en;
  logic [NBANK*BANK_AW-1:0] bank_addr;
  logic [NBANK*32-1:0]      bank_din;
  logic [NBANK*4-1:0]       bank_bytesel;
  logic [NBANK*32-1:0]      bank_dout;
  logic [NBANK-1:0]         bank_ready_nxt;

  modport slave (
    input  cpu_codeif_addr, cpu_codeif_req,
    output codeif_cpu_rdata, codeif_cpu_early_ready, codeif_cpu_err,
    input  cpu_dataif_addr, cpu_dataif_wdata, cpu_dataif_bytesel, cpu_dataif_req,
    output dataif_cpu_rdata, dataif_cpu_early_ready, dataif_cpu_err,
    output bank_en, bank_addr, bank_din, bank_bytesel,
    input  bank_dout, bank_ready_nxt
  );

  modport master (
    output cpu_codeif_addr, cpu_codeif_req,
    input  codeif_cpu_rdata, codeif_cpu_early_ready, codeif_cpu_err,
    output cpu_dataif_addr, cpu_dataif_wdata, cpu_dataif_bytesel, cpu_dataif_req,
    input  dataif_cpu_rdata, dataif_cpu_early_ready, dataif_cpu_err,
    input  bank_en, bank_addr, bank_din, bank_bytesel,
    output bank_dout, bank_ready_nxt
  );
endinterface

// File: rtl/nanorv32_tcm_mbank_arbitrer.sv
// Routes the nanorv32 code and data ports onto NBANK TCM banks by address, with data
// priority on bank conflicts, a bounded code-starvation escape and out-of-range errors.
module nanorv32_tcm_mbank_arbitrer #(
  parameter int NBANK      = 2,
  parameter int BANK_AW    = 13,
  parameter int STARVE_MAX = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  nanorv32_tcm_mbank_arbitrer_if.slave   bus
);
  localparam int BI = $clog2(NBANK);
  localparam int HI = BANK_AW + 2 + BI;
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [BI-1:0]      w_c_idx, w_d_idx;
  logic [BANK_AW-1:0] w_c_wa, w_d_wa;
  logic               w_c_oor, w_d_oor;
  logic               w_c_elig, w_d_elig;
  logic               w_conflict, w_code_pri;
  logic               w_c_gnt, w_d_gnt;
  logic               w_c_oor_acc, w_d_oor_acc;
  logic               w_c_acc, w_d_acc;
  logic               w_unused;

  logic [SW-1:0]      r_starve;
  logic               r_c_vld, r_c_err, r_d_vld, r_d_err;
  logic [BI-1:0]      r_c_idx, r_d_idx;

  // Address decode
  assign w_c_idx = bus.cpu_codeif_addr[BANK_AW+2 +: BI];
  assign w_d_idx = bus.cpu_dataif_addr[BANK_AW+2 +: BI];
  assign w_c_wa  = bus.cpu_codeif_addr[BANK_AW+1:2];
  assign w_d_wa  = bus.cpu_dataif_addr[BANK_AW+1:2];
  assign w_c_oor = |bus.cpu_codeif_addr[31:HI];
  assign w_d_oor = |bus.cpu_dataif_addr[31:HI];
  assign w_unused = &{1'b0, bus.cpu_codeif_addr[1:0], bus.cpu_dataif_addr[1:0]};

  // Eligibility and arbitration; a busy target bank never counts as a conflict
  assign w_c_elig   = rst_n & bus.cpu_codeif_req & ~w_c_oor & bus.bank_ready_nxt[w_c_idx];
  assign w_d_elig   = rst_n & bus.cpu_dataif_req & ~w_d_oor & bus.bank_ready_nxt[w_d_idx];
  assign w_conflict = w_c_elig & w_d_elig & (w_c_idx == w_d_idx);
  assign w_code_pri = (STARVE_MAX != 0) && (r_starve == SMAX);
  assign w_c_gnt    = w_c_elig & (~w_conflict | w_code_pri);
  assign w_d_gnt    = w_d_elig & (~w_conflict | ~w_code_pri);

  assign w_c_oor_acc = rst_n & bus.cpu_codeif_req & w_c_oor;
  assign w_d_oor_acc = rst_n & bus.cpu_dataif_req & w_d_oor;
  assign w_c_acc     = w_c_gnt | w_c_oor_acc;
  assign w_d_acc     = w_d_gnt | w_d_oor_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_c_gnt) begin
      r_starve <= '0;
    end else if (w_conflict && (r_starve != SMAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Response registers: one outstanding response per master, consumed in T+1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c_vld <= 1'b0;
      r_c_err <= 1'b0;
      r_d_vld <= 1'b0;
      r_d_err <= 1'b0;
    end else begin
      r_c_vld <= w_c_acc;
      r_c_err <= w_c_oor_acc;
      r_d_vld <= w_d_acc;
      r_d_err <= w_d_oor_acc;
    end
  end

  always_ff @(posedge clk) begin
    r_c_idx <= w_c_idx;
    r_d_idx <= w_d_idx;
  end

  always_comb begin
    bus.bank_en      = '0;
    bus.bank_addr    = '0;
    bus.bank_din     = '0;
    bus.bank_bytesel = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (w_d_gnt && (w_d_idx == BI'(k))) begin
        bus.bank_en[k]                      = 1'b1;
        bus.bank_addr[k*BANK_AW +: BANK_AW] = w_d_wa;
        bus.bank_din[k*32 +: 32]            = bus.cpu_dataif_wdata;
        bus.bank_bytesel[k*4 +: 4]          = bus.cpu_dataif_bytesel;
      end else if (w_c_gnt && (w_c_idx == BI'(k))) begin
        bus.bank_en[k]                      = 1'b1;
        bus.bank_addr[k*BANK_AW +: BANK_AW] = w_c_wa;
      end
    end
  end

  // Gating with rst_n drops a response that was pending when reset arrived
  assign bus.codeif_cpu_early_ready = w_c_acc;
  assign bus.dataif_cpu_early_ready = w_d_acc;
  assign bus.codeif_cpu_err   = rst_n & r_c_vld & r_c_err;
  assign bus.dataif_cpu_err   = rst_n & r_d_vld & r_d_err;
  assign bus.codeif_cpu_rdata = (rst_n && r_c_vld && !r_c_err) ? bus.bank_dout[32*r_c_idx +: 32] : 32'h0;
  assign bus.dataif_cpu_rdata = (rst_n && r_d_vld && !r_d_err) ? bus.bank_dout[32*r_d_idx +: 32] : 32'h0;
endmodule
